// File: rtl/result_collector.sv
// rtl/result_collector.sv - result FIFO with running sum, sticky overflow and saturating drop counter
module result_collector #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  input  logic                     clr,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [W+3:0]             acc,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    level_q, level_d;
  logic [W+3:0]   acc_q, acc_d;
  logic           overflow_q, overflow_d;
  logic [7:0]     drop_cnt_q, drop_cnt_d;
  logic           push, pop, drop;

  assign out_valid = (level_q != '0);
  // Head is gated so out_data reads 0 whenever the FIFO is empty, including after reset.
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;
  assign acc       = acc_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

  assign pop  = out_valid && out_ready;
  assign push = in_valid && ((level_q < FULL_LEVEL) || pop);
  assign drop = in_valid && !push;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    acc_d      = acc_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (clr) begin
      acc_d      = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (push) acc_d = acc_q + {4'b0000, in_data};
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      acc_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      acc_q      <= acc_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule
